// File: rtl/crossbar_v2.sv
// Operand crossbar for one RMT action stage: per-lane A/B/C operand selection from the PHV,
// registered together with the PHV remainder and action bus behind a two-entry skid buffer.
module crossbar_v2 #(
  parameter int unsigned NUM_CONT   = 8,
  parameter int unsigned CONT_W     = 32,
  parameter int unsigned IMM_W      = 16,
  parameter int unsigned ACT_W      = 25,
  parameter int unsigned REMAIN_W   = 256,
  parameter int unsigned IMM_SIGNED = 0
) (
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic [NUM_CONT*CONT_W+REMAIN_W-1:0] phv_in,
  input  logic [NUM_CONT*ACT_W-1:0]    action_in,
  input  logic                         in_valid,
  output logic                         in_ready,
  output logic [NUM_CONT*CONT_W-1:0]   alu_a,
  output logic [NUM_CONT*CONT_W-1:0]   alu_b,
  output logic [NUM_CONT*CONT_W-1:0]   alu_c,
  output logic [REMAIN_W-1:0]          remain_out,
  output logic [NUM_CONT*ACT_W-1:0]    action_out,
  output logic                         out_valid,
  input  logic                         out_ready
);

  localparam int unsigned SEL_W  = $clog2(NUM_CONT);
  localparam int unsigned LANE_W = NUM_CONT * CONT_W;
  localparam int unsigned ACTS_W = NUM_CONT * ACT_W;
  localparam int unsigned BEAT_W = 3 * LANE_W + ACTS_W + REMAIN_W;

  logic [CONT_W-1:0] cont [NUM_CONT];
  logic [LANE_W-1:0] a_flat, b_flat, c_flat;
  logic [BEAT_W-1:0] beat;

  for (genvar k = 0; k < NUM_CONT; k++) begin : g_cont
    assign cont[k] = phv_in[REMAIN_W + k*CONT_W +: CONT_W];
  end

  for (genvar g = 0; g < NUM_CONT; g++) begin : g_lane
    logic [ACT_W-1:0]  act;
    logic [3:0]        opc;
    logic [SEL_W-1:0]  sel_a, sel_b;
    logic [IMM_W-1:0]  imm;
    logic [CONT_W-1:0] imm_ext, src_a, src_b, op_a, op_b;

    assign act   = action_in[g*ACT_W +: ACT_W];
    assign opc   = act[ACT_W-1 -: 4];
    assign sel_a = act[IMM_W+SEL_W-1 : IMM_W];
    assign sel_b = act[IMM_W-1 -: SEL_W];
    assign imm   = act[IMM_W-1:0];

    // Selectors past the last container (non power-of-two lane counts) read as zero.
    assign src_a = (32'(sel_a) < NUM_CONT) ? cont[sel_a] : '0;
    assign src_b = (32'(sel_b) < NUM_CONT) ? cont[sel_b] : '0;

    always_comb begin
      imm_ext = {CONT_W{(IMM_SIGNED != 0) && imm[IMM_W-1]}};
      imm_ext[IMM_W-1:0] = imm;
    end

    always_comb begin
      op_a = cont[g];
      op_b = '0;
      case (opc)
        4'b0001, 4'b0010, 4'b0111, 4'b1000, 4'b1011: begin
          op_a = src_a;
          op_b = src_b;
        end
        4'b1001, 4'b1010: begin
          op_a = src_a;
          op_b = imm_ext;
        end
        4'b1110: begin
          op_a = '0;
          op_b = imm_ext;
        end
        default: ;
      endcase
    end

    assign a_flat[g*CONT_W +: CONT_W] = op_a;
    assign b_flat[g*CONT_W +: CONT_W] = op_b;
    assign c_flat[g*CONT_W +: CONT_W] = cont[g];
  end

  assign beat = {a_flat, b_flat, c_flat, action_in, phv_in[REMAIN_W-1:0]};

  // Skid buffer: M drives the outputs, S catches the beat accepted while M is stalled.
  logic              m_valid_q, m_valid_d, s_valid_q, s_valid_d, in_ready_q;
  logic [BEAT_W-1:0] m_q, m_d, s_q, s_d;
  logic              accept, drain;

  always_comb begin
    m_valid_d = m_valid_q;
    s_valid_d = s_valid_q;
    m_d       = m_q;
    s_d       = s_q;
    accept    = in_valid && in_ready_q;
    drain     = m_valid_q && out_ready;
    if (drain) begin
      if (s_valid_q) begin
        m_d       = s_q;
        s_valid_d = accept;
        if (accept) s_d = beat;
      end else begin
        m_valid_d = accept;
        if (accept) m_d = beat;
      end
    end else if (!m_valid_q) begin
      m_valid_d = accept;
      if (accept) m_d = beat;
    end else if (accept) begin
      s_valid_d = 1'b1;
      s_d       = beat;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_valid_q  <= 1'b0;
      s_valid_q  <= 1'b0;
      in_ready_q <= 1'b1;
      m_q        <= '0;
      s_q        <= '0;
    end else begin
      m_valid_q  <= m_valid_d;
      s_valid_q  <= s_valid_d;
      in_ready_q <= !s_valid_d;
      m_q        <= m_d;
      s_q        <= s_d;
    end
  end

  assign {alu_a, alu_b, alu_c, action_out, remain_out} = m_q;
  assign out_valid = m_valid_q;
  assign in_ready  = in_ready_q;

endmodule

// File: doc/crossbar_v2.md
# crossbar_v2

Parametrised operand crossbar for one RMT action stage. It sits between the PHV/action pipeline and the per-container ALU array. For every PHV container lane it selects operand A, operand B and the pass-through value C, driven by that lane's action word. It then presents the lane operands, the unmodified remainder of the PHV and the lane-aligned action bus to the ALUs through a fully registered valid/ready interface. A two-entry skid buffer gives full throughput without dropping beats.

## Interface
- NUM_CONT, 8, number of PHV containers/ALU lanes (2..64; need not be a power of two)
- CONT_W, 32, container width in bits
- IMM_W, 16, immediate field width (≤ CONT_W)
- ACT_W, 25, per-lane action word width; must satisfy ACT_W ≥ 4 + SEL_W + IMM_W
- REMAIN_W, 256, metadata/conditional tail of the PHV, passed through untouched
- IMM_SIGNED, 0, 1 = sign-extend immediate to CONT_W, 0 = zero-extend
- SEL_W (localparam), $clog2(NUM_CONT), source-selector width
- clk  in  1  clock
- rst_n  in  1  reset, asynchronous, active-low
- phv_in  in  NUM_CONT*CONT_W+REMAIN_W  container i = phv_in[REMAIN_W+i*CONT_W +: CONT_W]; remainder = phv_in[REMAIN_W-1:0]
- action_in  in  NUM_CONT*ACT_W  lane i action = action_in[i*ACT_W +: ACT_W]
- in_valid  in  1  phv_in and action_in valid (one beat)
- in_ready  out  1  crossbar can accept a beat
- alu_a, alu_b, alu_c  out  NUM_CONT*CONT_W each  lane i operands at [i*CONT_W +: CONT_W]
- remain_out  out  REMAIN_W  registered phv_in[REMAIN_W-1:0]
- action_out  out  NUM_CONT*ACT_W  action_in of the same beat
- out_valid  out  1  outputs valid
- out_ready  in  1  ALU array accepts

## Operation
- Action word fields:
  - opcode = [ACT_W-1 -: 4]
  - srcA = [IMM_W+SEL_W-1 : IMM_W]
  - srcB = [IMM_W-1 -: SEL_W]
  - imm = [IMM_W-1:0]
  - srcB and imm overlap; which one applies depends on the opcode.
- Per-lane selection (cont[k] = container k; ext(imm) per IMM_SIGNED):
  - opcodes 0001, 0010, 0111, 1000, 1011: A = cont[srcA], B = cont[srcB]
  - opcodes 1001, 1010: A = cont[srcA], B = ext(imm)
  - opcode 1110 (set): A = 0, B = ext(imm)
  - any other opcode (no-op): A = cont[i], B = 0
  - all opcodes: C = cont[i]
- A selector ≥ NUM_CONT (possible when NUM_CONT is not a power of two) yields 0 for that operand.
- All lanes are computed combinationally from the input beat and registered once. action_out and remain_out travel in the same register as the operands, so every output field belongs to one beat.
- Skid buffer: main output register M (drives the outputs) plus skid register S. Beat accepted when in_valid && in_ready.
  - Accepted beat goes to M if M is empty or out_ready=1 in that cycle; otherwise it goes to S.
  - When M drains (out_ready && out_valid) while S is full, S moves to M and S becomes empty.
  - When M drains, S is full and a new beat is accepted in the same cycle, S moves to M and the new beat goes to S.
- in_ready is a register: high iff S is empty after the current edge. It never depends combinationally on out_ready.
- out_valid stays high and M stays stable until out_ready is sampled high (AXI-stream rules). Beats are never dropped, duplicated or reordered.

## Timing
- Reset (async assert, sync release):
  - out_valid = 0
  - alu_a, alu_b, alu_c, remain_out and action_out = all zeros
  - S empty
  - in_ready = 1
- Latency: a beat accepted at edge N is on the outputs with out_valid=1 after edge N.
- Throughput: 1 beat/cycle while out_ready=1.
- Back-pressure:
  - First stalled beat lands in S; in_ready drops after that edge.
  - in_ready rises on the edge after M drains and S moves up.
- Capacity is exactly 2 beats (M + S). A 3rd beat is never accepted while out_ready=0.
- Reset mid-operation discards M and S immediately. No beat is emitted after rst_n deasserts until a new beat is accepted.

## Test plan
- Reset with stimulus active -> out_valid=0, all outputs 0, in_ready=1; first beat (cont[k]=k*0x11111111) with all no-ops -> next cycle alu_a lane k=cont[k], alu_b=0, alu_c=cont[k], remain_out=phv_in tail.
- Lane 3 opcode 0001, srcA=5, srcB=2 -> alu_a lane3=0x55555555, alu_b lane3=0x22222222. Lane 4 opcode 1001, srcA=7, imm=0x8001 -> A=0x77777777, B=0x00008001, or 0xFFFF8001 with IMM_SIGNED=1.
- Lane 0 opcode 1110, imm=0x1234 -> A=0, B=0x00001234, C=cont[0]. NUM_CONT=6 with srcA=7 -> A=0.
- Streaming 100 random beats with out_ready=1 -> 100 outputs in order, 1/cycle, latency 1, action_out and remain_out matching each beat.
- out_ready=0 for 5 cycles during continuous in_valid -> exactly 2 beats accepted, in_ready=0 from the 3rd cycle; out_ready=1 -> beats emerge in order, none lost.
- Random in_valid/out_ready toggling for 10k cycles against a reference model -> zero mismatches; out_valid and data held stable while out_ready=0.
